// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-cache memory arbiter: FSM state encoding,
// grant encoding, the default fill length and the beat counter width.
package mem_arb_pkg;

   // Number of mem_data_valid beats in one cache-block fill.
   localparam int BEATS_DEFAULT = 8;

   // The beat counter is 3 bits wide, so a fill can be at most 8 beats.
   localparam int BEAT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_I_FILL  = 2'd1,
      ST_D_FILL  = 2'd2,
      ST_D_WRITE = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_I    = 2'b01,
      GNT_D    = 2'b10
   } grant_e;

   // True for the two states that stream read beats from memory.
   function automatic logic is_fill(input arb_state_e s);
      return (s == ST_I_FILL) || (s == ST_D_FILL);
   endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter for cache-block fills. Clears while no fill is running,
// counts accepted read beats, and flags the last beat of a block.
module beat_counter
   import mem_arb_pkg::*;
#(
   parameter int BEATS = BEATS_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

   logic [BEAT_W-1:0] count_q;
   logic [BEAT_W-1:0] count_d;

   // Next count: clear has priority over increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + BEAT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Terminal count: the beat arriving now is the final one of the block.
   assign tc = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one multi-cycle memory between an I-cache (block fills)
// and a D-cache (block fills plus write-through writes).
//
// Optional build macro ARB_RR_EN: when defined, a d_re vs i_re conflict is
// settled by a 1-bit round-robin pointer instead of fixed D-over-I priority.
// d_we always wins regardless of the macro.
//
// Handshake: a request (i_re, d_re, d_we) is only looked at in IDLE; the grant
// is registered and the owning state starts the next cycle. Read beats are
// qualified by mem_data_valid, writes complete on mem_wdone; both are passed
// to the owner only, and ignored entirely in IDLE. A fill always runs to its
// last beat even if the owner drops its request, since data is in flight.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BEATS = BEATS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_addr,
   input  logic        i_re,
   output logic [15:0] i_din,
   output logic        i_data_valid,
   input  logic [15:0] d_addr,
   input  logic        d_re,
   input  logic        d_we,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_din,
   output logic        d_data_valid,
   output logic        d_wdone,
   output logic [15:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_data_valid,
   input  logic        mem_wdone,
   output logic [1:0]  grant,
   output logic [1:0]  dbg_state
);

   arb_state_e state_q;
   arb_state_e state_d;
   grant_e     grant_q;
   grant_e     grant_d;

   logic beat_clr;
   logic beat_inc;
   logic beat_tc;
   logic fill_done;
   logic d_wins_conflict;

   // The counter rests at zero in every non-fill state so each fill starts
   // from beat 0; only beats seen during a fill are counted.
   assign beat_clr  = !is_fill(state_q);
   assign beat_inc  = mem_data_valid && is_fill(state_q);
   assign fill_done = beat_inc && beat_tc;

   beat_counter #(
      .BEATS (BEATS)
   ) u_beat_counter (
      .clk (clk),
      .rst (rst),
      .clr (beat_clr),
      .inc (beat_inc),
      .tc  (beat_tc)
   );

`ifdef ARB_RR_EN
   // rr_q records which side the pointer last favoured; it starts at the
   // I-cache, so the first d_re/i_re conflict goes to the D-cache. It flips
   // on every completed fill.
   logic rr_q;
   logic rr_d;

   // Pointer update on each completed fill.
   always_comb begin
      rr_d = rr_q ^ fill_done;
   end

   // Round-robin pointer register; reset points at the I-cache.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign d_wins_conflict = (rr_q == 1'b0);
`else
   assign d_wins_conflict = 1'b1;
`endif

   // Next-state and grant: arbitrate in IDLE, hold the owner until done.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (d_we) begin
               state_d = ST_D_WRITE;
               grant_d = GNT_D;
            end else if (d_re && i_re) begin
               if (d_wins_conflict) begin
                  state_d = ST_D_FILL;
                  grant_d = GNT_D;
               end else begin
                  state_d = ST_I_FILL;
                  grant_d = GNT_I;
               end
            end else if (d_re) begin
               state_d = ST_D_FILL;
               grant_d = GNT_D;
            end else if (i_re) begin
               state_d = ST_I_FILL;
               grant_d = GNT_I;
            end else begin
               grant_d = GNT_NONE;
            end
         end
         ST_I_FILL, ST_D_FILL: begin
            if (fill_done) begin
               state_d = ST_IDLE;
               grant_d = GNT_NONE;
            end
         end
         ST_D_WRITE: begin
            if (mem_wdone) begin
               state_d = ST_IDLE;
               grant_d = GNT_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = GNT_NONE;
         end
      endcase
   end

   // State and grant registers; reset aborts any transfer immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= GNT_NONE;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Memory-side strobes and cache-side qualifiers, all decoded from the
   // registered state so nothing reaches memory or a cache while in IDLE.
   always_comb begin
      mem_addr     = '0;
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      i_data_valid = 1'b0;
      d_data_valid = 1'b0;
      d_wdone      = 1'b0;
      case (state_q)
         ST_I_FILL: begin
            mem_addr     = i_addr;
            mem_re       = i_re;
            mem_wdata    = d_wdata;
            i_data_valid = mem_data_valid;
         end
         ST_D_FILL: begin
            mem_addr     = d_addr;
            mem_re       = d_re;
            mem_wdata    = d_wdata;
            d_data_valid = mem_data_valid;
         end
         ST_D_WRITE: begin
            mem_addr  = d_addr;
            mem_re    = d_re;
            mem_we    = d_we;
            mem_wdata = d_wdata;
            d_wdone   = mem_wdone;
         end
         default: begin
         end
      endcase
   end

   // Read data goes to both caches; each cache only takes it on its valid.
   assign i_din     = mem_rdata;
   assign d_din     = mem_rdata;
   assign grant     = grant_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Stimulus tasks push every expected
// cache-side event ({kind, data}) into exp_q; a negedge monitor pops and
// compares whenever the DUT raises i_data_valid, d_data_valid or d_wdone.
// Direct checks cover grant, strobes and addresses at fixed points.
// Build with +define+ARB_RR_EN to exercise the round-robin variant.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam logic [1:0] K_I  = 2'd1;
   localparam logic [1:0] K_D  = 2'd2;
   localparam logic [1:0] K_WD = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] i_addr = '0;
   logic        i_re = 1'b0;
   logic [15:0] i_din;
   logic        i_data_valid;
   logic [15:0] d_addr = '0;
   logic        d_re = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_wdata = '0;
   logic [15:0] d_din;
   logic        d_data_valid;
   logic        d_wdone;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_data_valid = 1'b0;
   logic        mem_wdone = 1'b0;
   logic [1:0]  grant;
   logic [1:0]  dbg_state;

   logic [17:0] exp_q[$];
   int vectors = 0;
   int errors  = 0;

   mem_arbiter #(.BEATS(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_addr         (i_addr),
      .i_re           (i_re),
      .i_din          (i_din),
      .i_data_valid   (i_data_valid),
      .d_addr         (d_addr),
      .d_re           (d_re),
      .d_we           (d_we),
      .d_wdata        (d_wdata),
      .d_din          (d_din),
      .d_data_valid   (d_data_valid),
      .d_wdone        (d_wdone),
      .mem_addr       (mem_addr),
      .mem_re         (mem_re),
      .mem_we         (mem_we),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_data_valid (mem_data_valid),
      .mem_wdone      (mem_wdone),
      .grant          (grant),
      .dbg_state      (dbg_state)
   );

   // Clock and reset helpers
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Driver: present n read beats from memory; expected events go to exp_q.
   task automatic beats(input int n, input logic [15:0] base, input logic [1:0] kind);
      logic [15:0] v;
      for (int k = 0; k < n; k++) begin
         v = base + 16'(k);
         mem_data_valid = 1'b1;
         mem_rdata      = v;
         if (kind != 2'd0) exp_q.push_back({kind, v});
         tick();
      end
      mem_data_valid = 1'b0;
   endtask

   // Scoreboard monitor
   task automatic mon_pop(input string name, input logic [17:0] act);
      logic [17:0] e;
      if (exp_q.size() == 0) begin
         vectors++;
         errors++;
         $display("FAIL %s: got unexpected event %h, expected none", name, act);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(act), 32'(e));
      end
   endtask

   always @(negedge clk) begin
      if (i_data_valid === 1'b1) mon_pop("i_data", {K_I, i_din});
      if (d_data_valid === 1'b1) mon_pop("d_data", {K_D, d_din});
      if (d_wdone === 1'b1)      mon_pop("d_wdone", {K_WD, 16'h0000});
   end

   // Directed stimulus
   initial begin
      logic [1:0] exp_g;
      apply_reset();
      check("rst_grant", grant, GNT_NONE);
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_mem_re", mem_re, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 16'h0000);

      // Single I-cache fill
      i_addr = 16'h1230;
      i_re   = 1'b1;
      tick();
      check("i_fill_grant", grant, GNT_I);
      check("i_fill_state", dbg_state, ST_I_FILL);
      check("i_fill_addr", mem_addr, 16'h1230);
      check("i_fill_re", mem_re, 1'b1);
      beats(8, 16'hA000, K_I);
      i_re = 1'b0;
      check("i_fill_end_grant", grant, GNT_NONE);
      check("i_fill_end_state", dbg_state, ST_IDLE);

      // Owner drops i_re mid-fill; grant held to the 8th beat
      i_addr = 16'h2000;
      i_re   = 1'b1;
      tick();
      check("drop_grant", grant, GNT_I);
      beats(3, 16'hB000, K_I);
      i_re = 1'b0;
      #1;
      check("drop_grant_after3", grant, GNT_I);
      check("drop_mem_re", mem_re, 1'b0);
      beats(4, 16'hB003, K_I);
      check("drop_grant_after7", grant, GNT_I);
      beats(1, 16'hB007, K_I);
      check("drop_grant_after8", grant, GNT_NONE);

      // Both reads in IDLE: D first, then I after one IDLE cycle
      i_addr = 16'h1230;
      d_addr = 16'h3000;
      i_re   = 1'b1;
      d_re   = 1'b1;
      tick();
      check("both_first_grant", grant, GNT_D);
      check("both_first_addr", mem_addr, 16'h3000);
      beats(8, 16'hC000, K_D);
      d_re = 1'b0;
      check("both_gap_grant", grant, GNT_NONE);
      tick();
      check("both_second_grant", grant, GNT_I);
      check("both_second_addr", mem_addr, 16'h1230);
      beats(8, 16'hC100, K_I);
      i_re = 1'b0;
      check("both_end_grant", grant, GNT_NONE);

      // Write-through beats a pending I-cache read
      d_we    = 1'b1;
      d_wdata = 16'hBEEF;
      d_addr  = 16'h0040;
      i_re    = 1'b1;
      tick();
      check("wr_grant", grant, GNT_D);
      check("wr_state", dbg_state, ST_D_WRITE);
      check("wr_mem_we", mem_we, 1'b1);
      check("wr_mem_re", mem_re, 1'b0);
      check("wr_mem_addr", mem_addr, 16'h0040);
      check("wr_mem_wdata", mem_wdata, 16'hBEEF);
      mem_data_valid = 1'b1;
      mem_rdata      = 16'h1111;
      #1;
      check("wr_no_i_valid", i_data_valid, 1'b0);
      check("wr_no_d_valid", d_data_valid, 1'b0);
      tick();
      mem_data_valid = 1'b0;
      mem_wdone      = 1'b1;
      exp_q.push_back({K_WD, 16'h0000});
      tick();
      mem_wdone = 1'b0;
      d_we      = 1'b0;
      i_re      = 1'b0;
      check("wr_end_grant", grant, GNT_NONE);
      check("wr_end_mem_we", mem_we, 1'b0);
      tick();

      // Reset during the 5th beat aborts; late beats are dropped
      i_addr = 16'h5000;
      i_re   = 1'b1;
      tick();
      check("abort_grant", grant, GNT_I);
      beats(4, 16'hD000, K_I);
      mem_data_valid = 1'b1;
      mem_rdata      = 16'hD004;
      exp_q.push_back({K_I, 16'hD004});
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      i_re = 1'b0;
      check("abort_grant_after", grant, GNT_NONE);
      check("abort_state_after", dbg_state, ST_IDLE);
      check("abort_mem_re", mem_re, 1'b0);
      check("abort_late_i_valid", i_data_valid, 1'b0);
      beats(3, 16'hD005, 2'd0);
      mem_wdone = 1'b1;
      #1;
      check("idle_wdone_ignored", d_wdone, 1'b0);
      tick();
      mem_wdone = 1'b0;
      check("idle_after_late", dbg_state, ST_IDLE);

      // Both reads held continuously across four fills
      apply_reset();
      i_addr = 16'h1000;
      d_addr = 16'h2000;
      i_re   = 1'b1;
      d_re   = 1'b1;
      for (int n = 0; n < 4; n++) begin
`ifdef ARB_RR_EN
         exp_g = (n % 2 == 0) ? GNT_D : GNT_I;
`else
         exp_g = GNT_D;
`endif
         tick();
         check("held_grant", grant, exp_g);
         check("held_addr", mem_addr, (exp_g == GNT_D) ? 16'h2000 : 16'h1000);
         beats(8, 16'hE000 + 16'(n * 16), (exp_g == GNT_D) ? K_D : K_I);
         check("held_gap", grant, GNT_NONE);
      end
      i_re = 1'b0;
      d_re = 1'b0;

      tick();
      tick();
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
